retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Consumer end of the writeback stage's retire interface. Captures each 70-bit retire packet `{RF_wen, RF_waddr, RF_wdata, PC}` when an instruction completes writeback, queues it in a small FIFO, and drains it to the trace/evaluation logic over a valid/ready handshake. It also keeps a retired-instruction count and a dropped-packet count. It never back-pressures the CPU: on overflow it drops the newest packet and counts the drop.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, 32: width of `retire_cnt`.
- `DROP_W`, 16: width of `drop_cnt`.

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `retire_valid`  in  1  high for exactly the cycles the writeback stage completes an instruction.
- `inst_retire`  in  70  retire packet: [69] wen, [68:64] waddr, [63:32] wdata, [31:0] PC. Sampled only when `retire_valid`=1.
- `trace_valid`  out  1  head packet available.
- `trace_ready`  in  1  consumer accepts head.
- `trace_data`  out  70  head packet, same field layout.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `fifo_full`  out  1  level == DEPTH.
- `retire_cnt`  out  CNT_W  total packets presented (accepted + dropped).
- `drop_cnt`  out  DROP_W  packets dropped on full.
- `overflow`  out  1  sticky; set on first drop.

## Operation
- Push: `retire_valid`=1 and (not full, or pop in the same cycle) → write packet at `wptr`, `wptr`+1 mod DEPTH.
- Pop: `trace_valid`=1 and `trace_ready`=1 → `rptr`+1 mod DEPTH.
- Drop: `retire_valid`=1, full, and no pop this cycle → packet discarded, `drop_cnt` +1 (saturates at all-ones), `overflow` ← 1.
- Full with simultaneous push and pop → both happen; level unchanged; no drop.
- Empty with simultaneous push and pop → impossible (`trace_valid`=0), push only.
- `retire_cnt` +1 on every `retire_valid`, wraps modulo 2^CNT_W.
- `trace_data` = `mem[rptr]`; value is don't-care while `trace_valid`=0. Bench checks it only under valid.
- Pointers are $clog2(DEPTH)+1 bits. Full/empty come from the MSB compare. `fifo_level` = `wptr` − `rptr`.
- The packet content is not interpreted. Packets with wen=0 or waddr=0 are queued like any other.

## Timing
- Reset values: `trace_valid`=0, `fifo_level`=0, `fifo_full`=0, `retire_cnt`=0, `drop_cnt`=0, `overflow`=0, pointers 0. `trace_data` is don't-care.
- `rst` asserted mid-operation flushes all queued packets immediately (async). Counters clear. The first push is accepted at the first rising edge after `rst` deasserts.
- Push-to-visible latency: 1 cycle. A packet pushed at edge N into an empty FIFO gives `trace_valid`=1 after edge N. It can be popped at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- `trace_valid`/`trace_data` are registered-state driven. `trace_valid` does not depend combinationally on `trace_ready`.
- Holding rule: while `trace_valid`=1 and `trace_ready`=0, `trace_data` stays stable.
- All counters and flags update at the same edge as the push/drop they reflect.

## Structure
- Shared package `retire_pkg`:
  - `RETIRE_W`=70.
  - Field bounds `RT_WEN`=69, `RT_WADDR_HI/LO`=68/64, `RT_WDATA_HI/LO`=63/32, `RT_PC_HI/LO`=31/0.
  - Typedef `retire_pkt_t` as a packed struct of the four fields.
  - The writeback stage reuses this package.
- One sub-module, `retire_fifo`: a parameterised sync FIFO (width, depth) with push/pop/full/empty/level.
- The top holds the drop logic, counters and the sticky flag.

## Test plan
- Single retire into an empty FIFO: `inst_retire`={1,5'd3,32'hDEADBEEF,32'h0000_1000}, `trace_ready`=1 → `trace_valid` high one cycle later with the identical packet. Popped next edge. `retire_cnt`=1, `fifo_level` back to 0.
- Back-pressure fill: `trace_ready`=0, 8 consecutive retires with PC 0x0,0x4,…,0x1C → `fifo_full`=1, `fifo_level`=8. A 9th retire (PC 0x20) → `drop_cnt`=1, `overflow`=1, `retire_cnt`=9. Then `trace_ready`=1 drains PCs 0x0…0x1C in order; 0x20 never appears.
- Full with simultaneous push/pop: FIFO full, `trace_ready`=1 and `retire_valid`=1 in the same cycle → no drop, level stays 8. The new packet appears last.
- Wrap-around: 20 retires at one per cycle with `trace_ready`=1 → all 20 PCs emerge in order. No drops. `retire_cnt`=20.
- Async reset mid-stream: 3 queued, assert `rst` between edges → `trace_valid`, `fifo_level`, all counters 0 immediately. After release, a new packet flows with 1-cycle latency.
- `drop_cnt` saturation (DROP_W forced to 2): 5 drops → `drop_cnt`=3, stays 3.

Source files
------------

// File: rtl/retire_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : retire_pkg
// Purpose : Retire packet layout shared by writeback and trace logic.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package retire_pkg;

    localparam int RETIRE_W    = 70;
    localparam int RT_WEN      = 69;
    localparam int RT_WADDR_HI = 68;
    localparam int RT_WADDR_LO = 64;
    localparam int RT_WDATA_HI = 63;
    localparam int RT_WDATA_LO = 32;
    localparam int RT_PC_HI    = 31;
    localparam int RT_PC_LO    = 0;

    typedef struct packed {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } retire_pkt_t;

endpackage
`default_nettype wire

// File: rtl/retire_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : retire_fifo
// Purpose : Parameterised synchronous FIFO, pointer-MSB full/empty.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module retire_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int             c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_ptr_one = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[c_aw-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : retire_trace_buffer
// Purpose : Queues retire packets for trace, never stalls the CPU; counts drops.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module retire_trace_buffer
    import retire_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   retire_valid,
    input  logic [RETIRE_W-1:0]    inst_retire,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [RETIRE_W-1:0]    trace_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_full,
    output logic [CNT_W-1:0]       retire_cnt,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow
);

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_drop;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;

    assign w_pop  = !w_empty && trace_ready;
    assign w_drop = retire_valid && w_full && !w_pop;

    retire_fifo #(
        .WIDTH (RETIRE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (retire_valid),
        .i_pop   (w_pop),
        .i_wdata (inst_retire),
        .o_rdata (trace_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (retire_valid) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            // Drop count saturates rather than wrapping back to a misleading zero.
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign trace_valid = !w_empty;
    assign fifo_full   = w_full;
    assign retire_cnt  = r_retire_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_retire_trace_buffer
// Purpose : Scoreboard bench for retire_trace_buffer with directed vectors.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_retire_trace_buffer;
    import retire_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                retire_valid = 1'b0;
    logic [RETIRE_W-1:0] inst_retire = '0;
    logic                trace_valid;
    logic                trace_ready = 1'b0;
    logic [RETIRE_W-1:0] trace_data;
    logic [3:0]          fifo_level;
    logic                fifo_full;
    logic [31:0]         retire_cnt;
    logic [15:0]         drop_cnt;
    logic                overflow;

    logic                s_retire_valid = 1'b0;
    logic [RETIRE_W-1:0] s_inst_retire = '0;
    logic                s_trace_valid;
    logic                s_trace_ready = 1'b0;
    logic [RETIRE_W-1:0] s_trace_data;
    logic [1:0]          s_fifo_level;
    logic                s_fifo_full;
    logic [31:0]         s_retire_cnt;
    logic [1:0]          s_drop_cnt;
    logic                s_overflow;

    int errors = 0;
    int checks = 0;
    logic [RETIRE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(8), .CNT_W(32), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .inst_retire(inst_retire),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .retire_cnt(retire_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    retire_trace_buffer #(.DEPTH(2), .CNT_W(32), .DROP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .retire_valid(s_retire_valid), .inst_retire(s_inst_retire),
        .trace_valid(s_trace_valid), .trace_ready(s_trace_ready), .trace_data(s_trace_data),
        .fifo_level(s_fifo_level), .fifo_full(s_fifo_full), .retire_cnt(s_retire_cnt),
        .drop_cnt(s_drop_cnt), .overflow(s_overflow)
    );

    function automatic logic [RETIRE_W-1:0] pkt(input logic [31:0] pc);
        retire_pkt_t p;
        p.wen   = pc[2];
        p.waddr = pc[6:2];
        p.wdata = ~pc ^ 32'h5A5A_0000;
        p.pc    = pc;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input bit expect_accept);
        retire_valid = 1'b1;
        inst_retire  = pkt(pc);
        if (expect_accept) exp_q.push_back(pkt(pc));
        step();
        retire_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && trace_valid; k++) step();
        check({name, "_drained"}, {63'd0, trace_valid}, 64'd0);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted head packet must match the scoreboard front;
    // a stalled head must also match it (holding rule).
    always @(negedge clk) begin
        if (!rst && trace_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL trace_unexpected: got %h expected none", trace_data);
            end else if (trace_data !== exp_q[0]) begin
                errors++;
                $display("FAIL trace_data: got %h expected %h", trace_data, exp_q[0]);
                if (trace_ready) void'(exp_q.pop_front());
            end else if (trace_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        retire_pkt_t first;
        #2;
        check("rst_valid",    {63'd0, trace_valid}, 64'd0);
        check("rst_level",    64'(fifo_level), 64'd0);
        check("rst_full",     {63'd0, fifo_full}, 64'd0);
        check("rst_retire",   64'(retire_cnt), 64'd0);
        check("rst_drop",     64'(drop_cnt), 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single retire into empty FIFO
        first.wen = 1'b1; first.waddr = 5'd3; first.wdata = 32'hDEADBEEF; first.pc = 32'h0000_1000;
        trace_ready  = 1'b1;
        retire_valid = 1'b1;
        inst_retire  = first;
        exp_q.push_back(first);
        step();
        retire_valid = 1'b0;
        check("single_valid",  {63'd0, trace_valid}, 64'd1);
        check("single_level1", 64'(fifo_level), 64'd1);
        check("single_cnt",    64'(retire_cnt), 64'd1);
        step();
        check("single_level0", 64'(fifo_level), 64'd0);
        check("single_empty",  {63'd0, trace_valid}, 64'd0);

        // Back-pressure fill, then one drop
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) retire(32'(4 * i), 1'b1);
        check("fill_full",  {63'd0, fifo_full}, 64'd1);
        check("fill_level", 64'(fifo_level), 64'd8);
        check("fill_drop0", 64'(drop_cnt), 64'd0);
        retire(32'h20, 1'b0);
        check("drop_cnt",   64'(drop_cnt), 64'd1);
        check("drop_ovf",   {63'd0, overflow}, 64'd1);
        check("drop_retire", 64'(retire_cnt), 64'd10);
        check("drop_level", 64'(fifo_level), 64'd8);

        // Full with simultaneous push and pop: no drop, new packet last
        trace_ready = 1'b1;
        retire(32'h24, 1'b1);
        check("fullpp_level", 64'(fifo_level), 64'd8);
        check("fullpp_drop",  64'(drop_cnt), 64'd1);
        drain("fill");
        check("fill_retire", 64'(retire_cnt), 64'd11);

        // Wrap-around streaming at one per cycle
        for (int i = 0; i < 20; i++) retire(32'h100 + 32'(4 * i), 1'b1);
        drain("wrap");
        check("wrap_retire", 64'(retire_cnt), 64'd31);
        check("wrap_drop",   64'(drop_cnt), 64'd1);

        // Asynchronous reset mid-stream
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) retire(32'h200 + 32'(4 * i), 1'b1);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        #3 rst = 1'b1;
        #1;
        check("arst_valid",    {63'd0, trace_valid}, 64'd0);
        check("arst_level",    64'(fifo_level), 64'd0);
        check("arst_retire",   64'(retire_cnt), 64'd0);
        check("arst_drop",     64'(drop_cnt), 64'd0);
        check("arst_overflow", {63'd0, overflow}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        trace_ready = 1'b1;
        retire(32'h300, 1'b1);
        check("post_rst_valid",  {63'd0, trace_valid}, 64'd1);
        check("post_rst_retire", 64'(retire_cnt), 64'd1);
        step();
        check("post_rst_level",  64'(fifo_level), 64'd0);

        // Drop counter saturation on the DEPTH=2, DROP_W=2 instance
        for (int i = 0; i < 5; i++) begin
            s_retire_valid = 1'b1;
            s_inst_retire  = pkt(32'(4 * i));
            step();
        end
        check("sat_drop3",  64'(s_drop_cnt), 64'd3);
        for (int i = 0; i < 2; i++) step();
        s_retire_valid = 1'b0;
        check("sat_hold",   64'(s_drop_cnt), 64'd3);
        check("sat_ovf",    {63'd0, s_overflow}, 64'd1);
        check("sat_retire", 64'(s_retire_cnt), 64'd7);
        check("sat_level",  64'(s_fifo_level), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
